shreg_varlen_mc: RTL

- Multi-channel, variable-tap shift register for the SRL-inference regression set.
- Generalises the single-channel variable-length shreg with:
  - CHANNELS independent lanes;
  - clock enable;
  - an optional output register;
  - a fill counter with per-channel output-valid flags;
  - a RESET_EN mode choosing whether reset clears data (blocks SRL mapping) or only clears the fill/valid bookkeeping (SRL-mappable).
- Used as a synthesis target and as a delay-line primitive in datapath tests.

---
 rtl/shreg_varlen_mc.sv | 113 +++++++++++
 1 files changed

// File: rtl/shreg_varlen_mc.sv
`default_nettype none
// ============================================================================
// Module  : shreg_varlen_mc
// Purpose : Multi-channel variable-tap shift register with fill/valid tracking
//           and optional output register.
// Revision: 1.0 - initial release
// ============================================================================
module shreg_varlen_mc #(
    parameter int WIDTH    = 1,
    parameter int DEPTH    = 130,
    parameter int CHANNELS = 2,
    parameter int OUTREG   = 0,
    parameter int RESET_EN = 1
) (
    input  logic                         clk,
    input  logic                         r,
    input  logic                         ce,
    input  logic [CHANNELS*WIDTH-1:0]    i,
    input  logic [CHANNELS*32-1:0]       l,
    output logic [CHANNELS*WIDTH-1:0]    q,
    output logic [CHANNELS-1:0]          q_valid,
    output logic [$clog2(DEPTH+1)-1:0]   fill
);

    localparam int          FW      = $clog2(DEPTH + 1);
    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] c_depth = 32'(DEPTH);

    // Alternating power-up pattern, phase-shifted by lane and bit index.
    function automatic logic [DEPTH-1:0] init_pattern(input int ofs);
        logic [DEPTH-1:0] v;
        v = '0;
        for (int d = 0; d < DEPTH; d++) begin
            v[d] = ((d + ofs) % 2) == 0;
        end
        return v;
    endfunction

    logic [FW-1:0]             r_fill = '0;
    logic [CHANNELS*WIDTH-1:0] w_q;
    logic [CHANNELS-1:0]       w_valid;

    always_ff @(posedge clk) begin
        if (r) begin
            r_fill <= '0;
        end else if (ce && (r_fill != FW'(DEPTH))) begin
            r_fill <= r_fill + FW'(1);
        end
    end

    assign fill = r_fill;

    genvar gc, gw;
    generate
        for (gc = 0; gc < CHANNELS; gc++) begin : g_ch
            logic [31:0]   w_l;
            logic          w_inrange;
            logic [IW-1:0] w_idx;

            // Full 32-bit compare so out-of-range taps never alias onto a stage.
            assign w_l          = l[gc*32 +: 32];
            assign w_inrange    = w_l < c_depth;
            assign w_idx        = w_l[IW-1:0];
            assign w_valid[gc]  = w_inrange && (32'(r_fill) > w_l);

            for (gw = 0; gw < WIDTH; gw++) begin : g_bit
                localparam logic [DEPTH-1:0] c_init = init_pattern(gc + gw);

                logic [DEPTH-1:0] r_sr = c_init;

                // With RESET_EN=0 the chain has no reset term, keeping it SRL-mappable.
                always_ff @(posedge clk) begin
                    if (r) begin
                        if (RESET_EN != 0) begin
                            r_sr <= '0;
                        end
                    end else if (ce) begin
                        for (int d = DEPTH - 1; d > 0; d--) begin
                            r_sr[d] <= r_sr[d-1];
                        end
                        r_sr[0] <= i[gc*WIDTH + gw];
                    end
                end

                assign w_q[gc*WIDTH + gw] = w_inrange & r_sr[w_idx];
            end
        end

        if (OUTREG != 0) begin : g_outreg
            logic [CHANNELS*WIDTH-1:0] r_q;
            logic [CHANNELS-1:0]       r_valid;

            // Free-running (not ce-gated) so tap-select changes always propagate.
            always_ff @(posedge clk) begin
                if (r) begin
                    r_q     <= '0;
                    r_valid <= '0;
                end else begin
                    r_q     <= w_q;
                    r_valid <= w_valid;
                end
            end

            assign q       = r_q;
            assign q_valid = r_valid;
        end else begin : g_comb
            assign q       = w_q;
            assign q_valid = w_valid;
        end
    endgenerate

endmodule
`default_nettype wire
